// File: rtl/riscv_pkg.sv
// Shared pipeline types: register-address width, hazard FSM encoding and control-word presets.
// Every hazard_ctrl output pattern is one of the presets below.
package riscv_pkg;

  localparam int REG_AW = 5;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TO_FLUSH = 2'd2,
    ST_RSVD     = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
    logic ex_mem_hold;
    logic dmem_err;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
  localparam hz_ctl_t CTL_MEM_STALL = '{mem_wb_bubble: 1'b1, ex_mem_hold: 1'b1, default: 1'b0};
  localparam hz_ctl_t CTL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                     id_ex_bubble: 1'b1, default: 1'b0};
  localparam hz_ctl_t CTL_LOAD_USE = '{id_ex_bubble: 1'b1, default: 1'b0};
  localparam hz_ctl_t CTL_FLUSH = '{if_id_flush: 1'b1, id_ex_bubble: 1'b1, mem_wb_bubble: 1'b1,
                                    dmem_err: 1'b1, default: 1'b0};
  // Reset empties the pipe: no fetch advance, every stage register bubbled.
  localparam hz_ctl_t CTL_RESET = '{if_id_flush: 1'b1, id_ex_bubble: 1'b1, mem_wb_bubble: 1'b1,
                                    default: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle; master is the pipeline, slave is hazard_ctrl.
// Purely wires: no latency, no flow control of its own.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import riscv_pkg::*;

  reg_addr_t        id_rs1;
  reg_addr_t        id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  reg_addr_t        ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             mem_wb_bubble;
  logic             ex_mem_hold;
  logic             dmem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_wb_bubble,
           ex_mem_hold, dmem_err, state, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_wb_bubble,
           ex_mem_hold, dmem_err, state, stall_cycles
  );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction reading the destination of a load still in EX.
// Combinational, zero latency; x0 never creates a dependency.
module load_use_detect
  import riscv_pkg::*;
(
  input  reg_addr_t id_rs1,
  input  reg_addr_t id_rs2,
  input  logic      id_use_rs1,
  input  logic      id_use_rs2,
  input  reg_addr_t ex_rd,
  input  logic      ex_mem_read,
  output logic      load_use
);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait with timeout flush.
// Outputs combinational from state/inputs; a dmem stall lasts at most WAIT_LIMIT+1 cycles.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int WCNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT_C = WCNT_W'(WAIT_LIMIT);

  hz_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              load_use;
  hz_ctl_t           ctl;

  load_use_detect u_load_use_detect (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_use_rs1  (hz.id_use_rs1),
    .id_use_rs2  (hz.id_use_rs2),
    .ex_rd       (hz.ex_rd),
    .ex_mem_read (hz.ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctl        = CTL_RUN;
    case (state_q)
      ST_RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          ctl        = CTL_MEM_STALL;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else if (hz.ex_branch_taken) begin
          // A taken branch also squashes any load-use victim sitting in ID.
          ctl = CTL_BRANCH;
        end else if (load_use) begin
          ctl = CTL_LOAD_USE;
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT_C) begin
          ctl        = CTL_MEM_STALL;
          state_d    = ST_TO_FLUSH;
          wait_cnt_d = '0;
        end else begin
          ctl        = CTL_MEM_STALL;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_TO_FLUSH: begin
        ctl     = CTL_FLUSH;
        state_d = ST_RUN;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (rst) ctl = CTL_RESET;

    stall_cycles_d = stall_cycles_q;
    if (!ctl.pc_write && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.pc_write      = ctl.pc_write;
  assign hz.if_id_write   = ctl.if_id_write;
  assign hz.if_id_flush   = ctl.if_id_flush;
  assign hz.id_ex_bubble  = ctl.id_ex_bubble;
  assign hz.mem_wb_bubble = ctl.mem_wb_bubble;
  assign hz.ex_mem_hold   = ctl.ex_mem_hold;
  assign hz.dmem_err      = ctl.dmem_err;
  assign hz.state         = state_q;
  assign hz.stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vectors for hazard_ctrl; expected outputs queued by the driver, checked by a monitor.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       memrd;
    logic [4:0] exrd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        mwb;
    logic        hold;
    logic        err;
    logic [1:0]  st;
    logic [15:0] stall;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  exp_t  exp_q[$];
  string nm_q[$];

  hazard_ctrl_if #(.CNT_W(16)) hif ();

  hazard_ctrl #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t I(input logic r, input logic memrd, input logic [4:0] exrd,
                            input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic br, input logic req, input logic rdy);
    in_t v;
    v = '{rst: r, memrd: memrd, exrd: exrd, rs1: rs1, u1: u1, rs2: rs2, u2: u2,
          br: br, req: req, rdy: rdy};
    return v;
  endfunction

  function automatic exp_t X(input logic pcw, input logic ifw, input logic fl, input logic bub,
                             input logic mwb, input logic hold, input logic err,
                             input logic [1:0] st, input int stall);
    exp_t v;
    v = '{pcw: pcw, ifw: ifw, fl: fl, bub: bub, mwb: mwb, hold: hold, err: err,
          st: st, stall: 16'(stall)};
    return v;
  endfunction

  task automatic apply(input in_t v);
    rst                 = v.rst;
    hif.ex_mem_read     = v.memrd;
    hif.ex_rd           = v.exrd;
    hif.id_rs1          = v.rs1;
    hif.id_use_rs1      = v.u1;
    hif.id_rs2          = v.rs2;
    hif.id_use_rs2      = v.u2;
    hif.ex_branch_taken = v.br;
    hif.dmem_req        = v.req;
    hif.dmem_ready      = v.rdy;
  endtask

  task automatic cyc(input string nm, input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: every cycle the controller presents a full control word.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      a = '{pcw: hif.pc_write, ifw: hif.if_id_write, fl: hif.if_id_flush,
            bub: hif.id_ex_bubble, mwb: hif.mem_wb_bubble, hold: hif.ex_mem_hold,
            err: hif.dmem_err, st: hif.state, stall: hif.stall_cycles};
      n_checks++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got pcw/ifw/fl/bub/mwb/hold/err=%b%b%b%b%b%b%b st=%0d stall=%0d, expected %b%b%b%b%b%b%b st=%0d stall=%0d",
                 nm, a.pcw, a.ifw, a.fl, a.bub, a.mwb, a.hold, a.err, a.st, a.stall,
                 e.pcw, e.ifw, e.fl, e.bub, e.mwb, e.hold, e.err, e.st, e.stall);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t idle;
    in_t memwait;
    n_checks = 0;
    n_err    = 0;
    idle     = I(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    memwait  = I(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    apply(I(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0));
    #1;
    rst = 1'b1;

    cyc("reset",     I(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0), X(0,0,1,1,1,0,0,0,0));
    cyc("idle0",     idle,                                     X(1,1,0,0,0,0,0,0,0));
    cyc("lu_rs1",    I(0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0), X(0,0,0,1,0,0,0,0,0));
    cyc("lu_after",  idle,                                     X(1,1,0,0,0,0,0,0,1));
    cyc("lu_rd0",    I(0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0), X(1,1,0,0,0,0,0,0,1));
    cyc("lu_rs2",    I(0, 1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0, 0), X(0,0,0,1,0,0,0,0,1));
    cyc("lu_nouse",  I(0, 1, 5'd7, 5'd3, 1, 5'd7, 0, 0, 0, 0), X(1,1,0,0,0,0,0,0,2));
    cyc("lu_noload", I(0, 0, 5'd5, 5'd5, 1, 5'd5, 1, 0, 0, 0), X(1,1,0,0,0,0,0,0,2));
    cyc("br_lu",     I(0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 0), X(1,1,1,1,0,0,0,0,2));
    // dmem stall outranks a simultaneous branch; MEM_WAIT ignores branch/load-use.
    cyc("mw_run",    I(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0), X(0,0,0,0,1,1,0,0,2));
    cyc("mw_1",      I(0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 1, 1, 0), X(0,0,0,0,1,1,0,1,3));
    cyc("mw_2",      memwait,                                  X(0,0,0,0,1,1,0,1,4));
    cyc("mw_ready",  I(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1), X(1,1,0,0,0,0,0,1,5));
    cyc("mw_after",  idle,                                     X(1,1,0,0,0,0,0,0,5));

    cyc("to_run",    memwait,                                  X(0,0,0,0,1,1,0,0,5));
    for (int k = 1; k <= 15; k++)
      cyc("to_wait", memwait,                                  X(0,0,0,0,1,1,0,1,5 + k));
    cyc("to_flush",  memwait,                                  X(0,0,1,1,1,0,1,2,21));
    cyc("to_back",   idle,                                     X(1,1,0,0,0,0,0,0,22));
    cyc("to_idle",   idle,                                     X(1,1,0,0,0,0,0,0,22));

    cyc("rw_run",    memwait,                                  X(0,0,0,0,1,1,0,0,22));
    cyc("rw_wait1",  memwait,                                  X(0,0,0,0,1,1,0,1,23));
    cyc("rw_rst",    I(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0), X(0,0,1,1,1,0,0,0,0));
    cyc("rw_release", idle,                                    X(1,1,0,0,0,0,0,0,0));
    cyc("rw_idle",   idle,                                     X(1,1,0,0,0,0,0,0,0));

    @(negedge clk);
    #1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, SHALL be the maximum number of consecutive dmem_ready-low cycles tolerated before a timeout.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of the stall performance counter.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source.
REQ-007 ex_rd  in  5  destination of the instruction in EX; ex_mem_read  in  1  EX holds a load.
REQ-008 ex_branch_taken  in  1  EX resolved a taken branch or jump (redirect this cycle).
REQ-009 dmem_req  in  1  MEM stage has an access outstanding; dmem_ready  in  1  data memory completes it this cycle.
REQ-010 pc_write, if_id_write  out  1 each  enables for PC and IF/ID registers.
REQ-011 if_id_flush, id_ex_bubble, mem_wb_bubble  out  1 each  zero IF/ID, insert NOP into ID/EX, insert NOP into MEM/WB.
REQ-012 ex_mem_hold  out  1  freeze ID/EX and EX/MEM registers.
REQ-013 dmem_err  out  1  one-cycle timeout pulse; state  out  2  current FSM state.
REQ-014 stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-015 FSM states SHALL be RUN=2'd0, MEM_WAIT=2'd1, TO_FLUSH=2'd2; 2'd3 SHALL transition to RUN.
REQ-016 load_use SHALL be ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-017 RUN, priority 1: dmem_req & !dmem_ready SHALL assert pc_write=0, if_id_write=0, ex_mem_hold=1, mem_wb_bubble=1, and next state MEM_WAIT with wait_cnt=1.
REQ-018 RUN, priority 2: ex_branch_taken SHALL assert if_id_flush=1 and id_ex_bubble=1 with pc_write=1 and if_id_write=1; state stays RUN.
REQ-019 RUN, priority 3: load_use SHALL assert pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; state stays RUN.
REQ-020 RUN with none of REQ-017..019 SHALL drive pc_write=1, if_id_write=1, all flush/bubble/hold outputs 0.
REQ-021 Branch and load_use together SHALL resolve as branch (REQ-018); the load-use instruction is discarded.
REQ-022 MEM_WAIT SHALL drive the REQ-017 output set every cycle, ignoring ex_branch_taken and load_use.
REQ-023 MEM_WAIT with dmem_ready=1 SHALL return to RUN next cycle with outputs released the same cycle.
REQ-024 MEM_WAIT with dmem_ready=0 and wait_cnt==WAIT_LIMIT SHALL go to TO_FLUSH; otherwise wait_cnt increments.
REQ-025 TO_FLUSH SHALL last one cycle: dmem_err=1, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, pc_write=0, ex_mem_hold=0; then RUN.
REQ-026 Outputs SHALL be combinational from state and inputs; state, wait_cnt, stall_cycles registered.
REQ-027 stall_cycles SHALL increment on each clock edge where pc_write=0 and hold at 2^CNT_W-1.

Reset
REQ-028 rst high SHALL immediately force state=RUN, wait_cnt=0, stall_cycles=0, dmem_err=0, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, ex_mem_hold=0.
REQ-029 rst asserted mid-MEM_WAIT SHALL abandon the wait without dmem_err; first cycle after release is RUN.

Structure
REQ-030 State encoding and register-address width (5) SHALL live in the shared riscv_pkg package.
REQ-031 The load_use compare SHALL be a combinational sub-module load_use_detect.

Verification
REQ-032 ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_write=0, id_ex_bubble=1 that cycle only; stall_cycles=1.
REQ-033 Same as REQ-032 but ex_rd=0 -> no stall, pc_write=1.
REQ-034 ex_branch_taken=1 with load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1.
REQ-035 dmem_req=1, dmem_ready low 3 cycles then high -> state MEM_WAIT for 3 cycles, ex_mem_hold=1 throughout, RUN after; stall_cycles=3.
REQ-036 dmem_req=1, dmem_ready held 0 -> after 16 stalled cycles state=TO_FLUSH, dmem_err pulses once, then RUN.
REQ-037 rst asserted in 2nd MEM_WAIT cycle -> state=RUN, stall_cycles=0, dmem_err never asserted.
